// File: rtl/gbox_tx66.sv
// gbox_tx66: 66b block -> 32b word transmit gearbox, inserts IDLE command blocks on underrun.
// Latency: word_en_i -> word_o/word_valid_o exactly 1 cycle; bits leave in arrival order, MSB first.
// Backpressure: blk_ready_o is registered, high while fewer than 64 bits will remain buffered.
// Optional: `define TX_BITSLIP_EN adds slip_i (one 0 bit inserted per pulse) and grows the buffer to 130b.
module gbox_tx66 #(
   parameter logic [1:0]  IDLE_HEADER  = 2'b10,
   parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  blk_hdr_i,
   input  logic [63:0] blk_data_i,
   input  logic        blk_valid_i,
   output logic        blk_ready_o,
   input  logic        word_en_i,
`ifdef TX_BITSLIP_EN
   input  logic        slip_i,
`endif
   output logic [31:0] word_o,
   output logic        word_valid_o,
   output logic        fill_o,
   output logic        hdr_err_o
);

`ifdef TX_BITSLIP_EN
   localparam int BUF_W = 130;
`else
   localparam int BUF_W = 129;
`endif
   localparam logic [7:0] BUF_W_C = 8'(BUF_W);

   // Left-aligned shift buffer: oldest bit at r_buf[BUF_W-1], bits below r_cnt are always 0.
   logic [BUF_W-1:0] r_buf;
   logic [7:0]       r_cnt;
   logic             r_blk_ready;
   logic [31:0]      r_word;
   logic             r_word_valid;
   logic             r_fill;
   logic             r_hdr_err;

   logic             w_accept;
   logic             w_fill;
   logic             w_append;
   logic             w_slip;
   logic             w_hdr_bad;
   logic [65:0]      w_blk;
   logic [8:0]       w_ofs;
   logic [8:0]       w_sum;
   logic [7:0]       w_cnt_next;
   logic [BUF_W-1:0] w_app;
   logic [BUF_W-1:0] w_merged;
   logic [BUF_W-1:0] w_buf_next;

   // Merge appended bits behind the valid ones, then strip the emitted word off the top.
   always_comb begin
`ifdef TX_BITSLIP_EN
      // A slip bit is simply an extra 0 at the tail; the buffer below r_cnt is already 0.
      w_slip = slip_i && (r_cnt < BUF_W_C);
`else
      w_slip = 1'b0;
`endif
      w_accept  = blk_valid_i && r_blk_ready;
      // Filler only when the serializer would otherwise be short of a full word.
      w_fill    = word_en_i && (r_cnt < 8'd32) && !w_accept;
      w_append  = w_accept || w_fill;
      w_hdr_bad = w_accept && ((blk_hdr_i == 2'b00) || (blk_hdr_i == 2'b11));
      w_blk     = w_accept ? {blk_hdr_i, blk_data_i} : {IDLE_HEADER, IDLE_PAYLOAD};
      w_ofs     = {1'b0, r_cnt} + {8'd0, w_slip};
      w_app     = '0;
      if (w_append) begin
         w_app = {w_blk, {(BUF_W-66){1'b0}}} >> w_ofs;
      end
      w_merged   = r_buf | w_app;
      w_buf_next = word_en_i ? (w_merged << 32) : w_merged;
      w_sum      = {1'b0, r_cnt}
                 + (w_append ? 9'd66 : 9'd0)
                 + {8'd0, w_slip}
                 - (word_en_i ? 9'd32 : 9'd0);
      w_cnt_next = w_sum[7:0];
   end

   // Buffer, fill level and registered ready track the post-cycle occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_buf       <= '0;
         r_cnt       <= 8'd0;
         r_blk_ready <= 1'b0;
      end else begin
         r_buf       <= w_buf_next;
         r_cnt       <= w_cnt_next;
         r_blk_ready <= (w_cnt_next < 8'd64);
      end
   end

   // Output word register holds its value when no word is requested; status pulses last one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
         r_fill       <= 1'b0;
         r_hdr_err    <= 1'b0;
      end else begin
         if (word_en_i) begin
            r_word <= w_merged[BUF_W-1 -: 32];
         end
         r_word_valid <= word_en_i;
         r_fill       <= w_fill;
         r_hdr_err    <= w_hdr_bad;
      end
   end

   assign blk_ready_o  = r_blk_ready;
   assign word_o       = r_word;
   assign word_valid_o = r_word_valid;
   assign fill_o       = r_fill;
   assign hdr_err_o    = r_hdr_err;

endmodule

// File: tb/tb_gbox_tx66.sv
`timescale 1ns/1ps
module tb_gbox_tx66;

   localparam logic [1:0]  IDLE_H = 2'b10;
   localparam logic [63:0] IDLE_P = 64'h7800_0000_0000_0000;
`ifdef TX_BITSLIP_EN
   localparam int CAP = 130;
`else
   localparam int CAP = 129;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [1:0]  blk_hdr_i = 2'b00;
   logic [63:0] blk_data_i = 64'd0;
   logic        blk_valid_i = 1'b0;
   logic        blk_ready_o;
   logic        word_en_i = 1'b0;
`ifdef TX_BITSLIP_EN
   logic        slip_i = 1'b0;
`endif
   logic [31:0] word_o;
   logic        word_valid_o;
   logic        fill_o;
   logic        hdr_err_o;

   gbox_tx66 dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .blk_hdr_i    (blk_hdr_i),
      .blk_data_i   (blk_data_i),
      .blk_valid_i  (blk_valid_i),
      .blk_ready_o  (blk_ready_o),
      .word_en_i    (word_en_i),
`ifdef TX_BITSLIP_EN
      .slip_i       (slip_i),
`endif
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .fill_o       (fill_o),
      .hdr_err_o    (hdr_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        vld;
      logic [31:0] word;
      logic        fill;
      logic        herr;
      logic        rdy;
   } exp_t;

   exp_t        rec_q[$];   // one expected output record per driven cycle
   logic [31:0] got_q[$];   // words observed from the DUT, for hand-computed spot checks
   bit          ref_bits[$]; // reference line bitstream still waiting to be emitted
   logic        m_rdy = 1'b0;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: outputs registered at this edge belong to the record pushed the half-cycle before.
   always @(posedge clk_i) begin
      exp_t e;
      #1;
      if (rst_ni) begin
         if (rec_q.size() > 0) begin
            e = rec_q.pop_front();
            chk("word_valid", {31'd0, word_valid_o}, {31'd0, e.vld});
            chk("blk_ready", {31'd0, blk_ready_o}, {31'd0, e.rdy});
            chk("fill", {31'd0, fill_o}, {31'd0, e.fill});
            chk("hdr_err", {31'd0, hdr_err_o}, {31'd0, e.herr});
            if (e.vld && word_valid_o) chk("word", word_o, e.word);
         end else if (word_valid_o) begin
            chk("unexpected_word_valid", {31'd0, word_valid_o}, 32'd0);
         end
         if (word_valid_o) got_q.push_back(word_o);
      end
   end

   // Drive one cycle of inputs and push the expected response from the bitstream reference.
   task automatic drive(input logic vld, input logic [1:0] hdr, input logic [63:0] dat,
                        input logic en, input logic slp, output logic acc);
      exp_t        e;
      logic        fil;
      logic        sl;
      logic [65:0] b;
      blk_valid_i = vld;
      blk_hdr_i   = hdr;
      blk_data_i  = dat;
      word_en_i   = en;
`ifdef TX_BITSLIP_EN
      slip_i = slp;
`endif
      sl  = slp && (ref_bits.size() < CAP);
      acc = vld && m_rdy;
      fil = en && (ref_bits.size() < 32) && !acc;
      if (sl) ref_bits.push_back(1'b0);
      if (acc || fil) begin
         b = acc ? {hdr, dat} : {IDLE_H, IDLE_P};
         for (int i = 65; i >= 0; i--) ref_bits.push_back(b[i]);
      end
      e.word = 32'd0;
      if (en) begin
         for (int i = 31; i >= 0; i--) begin
            if (ref_bits.size() > 0) e.word[i] = ref_bits.pop_front();
         end
      end
      e.vld  = en;
      e.fill = fil;
      e.herr = acc && ((hdr == 2'b00) || (hdr == 2'b11));
      e.rdy  = (ref_bits.size() < 64);
      m_rdy  = e.rdy;
      rec_q.push_back(e);
   endtask

   task automatic step(input logic vld, input logic [1:0] hdr, input logic [63:0] dat,
                       input logic en, input logic slp, output logic acc);
      @(negedge clk_i);
      drive(vld, hdr, dat, en, slp, acc);
   endtask

   task automatic idle(input int n, input logic en);
      logic a;
      for (int k = 0; k < n; k++) step(1'b0, 2'b00, 64'd0, en, 1'b0, a);
   endtask

   task automatic do_reset();
      logic a;
      @(negedge clk_i);
      rst_ni = 1'b0;
      drive(1'b0, 2'b00, 64'd0, 1'b0, 1'b0, a);
      repeat (5) @(negedge clk_i);
      chk("rst_word", word_o, 32'd0);
      chk("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
      chk("rst_blk_ready", {31'd0, blk_ready_o}, 32'd0);
      chk("rst_fill", {31'd0, fill_o}, 32'd0);
      chk("rst_hdr_err", {31'd0, hdr_err_o}, 32'd0);
      rec_q.delete();
      ref_bits.delete();
      got_q.delete();
      m_rdy  = 1'b0;
      rst_ni = 1'b1;
      #1;
      chk("rdy_cycle1_after_release", {31'd0, blk_ready_o}, 32'd0);
      // Same cycle: record expects blk_ready_o = 1 after the first edge.
      drive(1'b0, 2'b00, 64'd0, 1'b0, 1'b0, a);
   endtask

   initial begin
      logic        a;
      int          idx;
      logic [7:0]  ib;

      // Reset and readiness.
      do_reset();
      idle(2, 1'b0);

      // Line rate: 16 back-to-back data blocks, word every cycle.
      got_q.delete();
      idx = 1;
      for (int c = 0; c < 33; c++) begin
         ib = 8'(idx);
         step(idx <= 16, 2'b01, {8{ib}}, 1'b1, 1'b0, a);
         if (a) idx++;
      end
      idle(2, 1'b0);
      chk("line_rate_blocks_taken", idx - 1, 32'd16);
      chk("line_rate_word_count", got_q.size(), 32'd33);
      if (got_q.size() > 0) chk("line_rate_first_word", got_q[0], 32'h4040_4040);

      // Underrun: only filler blocks on the line.
      got_q.delete();
      idle(10, 1'b1);
      idle(2, 1'b0);
      chk("underrun_word_count", got_q.size(), 32'd10);
      if (got_q.size() >= 3) begin
         chk("underrun_w0", got_q[0], 32'h9E00_0000);
         chk("underrun_w1", got_q[1], 32'h0000_0000);
         chk("underrun_w2", got_q[2], 32'h2780_0000);
      end

      // Backpressure: no words drawn, one block fills the buffer past 64 bits.
      do_reset();
      idle(1, 1'b0);
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 2'b01, 64'h1111_2222_3333_4444 + 64'(idx), 1'b0, 1'b0, a);
         if (a) idx++;
      end
      @(negedge clk_i);
      chk("bp_ready_low", {31'd0, blk_ready_o}, 32'd0);
      drive(1'b1, 2'b01, 64'h1111_2222_3333_4444 + 64'(idx), 1'b0, 1'b0, a);
      if (a) idx++;
      for (int c = 0; c < 14; c++) begin
         step(idx < 4, 2'b01, 64'h1111_2222_3333_4444 + 64'(idx), 1'b1, 1'b0, a);
         if (a) idx++;
      end
      idle(4, 1'b1);
      idle(2, 1'b0);

      // Mid-operation reset, then an illegal header forwarded unchanged.
      for (int c = 0; c < 3; c++) step(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0000, 1'b1, 1'b0, a);
      do_reset();
      step(1'b1, 2'b11, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 1'b0, a);
      idle(4, 1'b1);
      idle(2, 1'b0);
      if (got_q.size() > 0) chk("illegal_hdr_first_word", got_q[0], 32'hE969_6969);
      else chk("illegal_hdr_word_seen", got_q.size(), 32'd1);

`ifdef TX_BITSLIP_EN
      // One slip mid-stream, then 66 more to walk a full block period.
      idx = 0;
      for (int c = 0; c < 120; c++) begin
         step(1'b1, 2'b01, {32'hC0DE_0000, 32'(idx)}, 1'b1, (c == 5) || (c >= 20 && c < 86), a);
         if (a) idx++;
      end
      idle(6, 1'b1);
      idle(2, 1'b0);
`endif

      // Every pushed expectation must have been consumed by the monitor.
      repeat (3) @(negedge clk_i);
      chk("records_drained", rec_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
